// File: rtl/spi_slave_pkg.sv
// Shared types and constants for the SPI-slave bus-request bridge.
// The optional error tracking is enabled by defining SPI_SLAVE_REQ_ERR_EN.
package spi_slave_pkg;

    localparam int ADDR_W             = 32;
    localparam int DATA_W             = 32;
    localparam int DEFAULT_WORD_BYTES = 4;

    localparam logic [7:0] ERR_CNT_MAX = 8'hFF;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WDATA,
        ST_REQ,
        ST_RESP,
        ST_PUSH
    } state_t;

endpackage

// File: rtl/spi_slave_edge_det.sv
// Rising-edge detector: registers the previous level and flags a 0->1 step
// in the same cycle the new level arrives.
module spi_slave_edge_det (
    input  logic sys_clk,
    input  logic rst,
    input  logic level,
    output logic rise
);

    logic level_q;

    // NOTE: flops use non-blocking assignments so every register samples the
    // pre-edge value of every other register, independent of block order.
    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            level_q <= 1'b0;
        end else begin
            level_q <= level;
        end
    end

    assign rise = level & ~level_q;

endmodule

// File: rtl/spi_slave_bus_req.sv
// Turns an SPI-side transfer (start address + data streams) into word-wise bus
// requests with auto-increment; error tracking is built when SPI_SLAVE_REQ_ERR_EN is defined.
module spi_slave_bus_req
    import spi_slave_pkg::*;
#(
    parameter int WORD_BYTES = DEFAULT_WORD_BYTES
) (
    input  logic              sys_clk,
    input  logic              rst,
    input  logic              cs_sync,
    input  logic [ADDR_W-1:0] address_sync,
    input  logic              address_valid_sync,
    input  logic              rd_wr_sync,
    input  logic [DATA_W-1:0] rx_data,
    input  logic              rx_valid,
    output logic              rx_ready,
    output logic [DATA_W-1:0] tx_data,
    output logic              tx_valid,
    input  logic              tx_ready,
    output logic              req_valid,
    input  logic              req_ready,
    output logic [ADDR_W-1:0] req_addr,
    output logic              req_we,
    output logic [DATA_W-1:0] req_wdata,
    input  logic              rsp_valid,
    input  logic [DATA_W-1:0] rsp_rdata,
    input  logic              rsp_err,
    output logic              busy,
    output logic              err_flag,
    output logic [7:0]        err_cnt
);

    localparam logic [ADDR_W-1:0] ADDR_INC = ADDR_W'(WORD_BYTES);

    state_t state;
    logic   abort;
    logic   start_rise;
    logic   start;

    spi_slave_edge_det u_edge_det (
        .sys_clk (sys_clk),
        .rst     (rst),
        .level   (address_valid_sync),
        .rise    (start_rise)
    );

    assign start = start_rise & ~cs_sync;

    // req_addr doubles as the running word address; it wraps modulo 2^32.
    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            abort     <= 1'b0;
            busy      <= 1'b0;
            req_valid <= 1'b0;
            req_addr  <= '0;
            req_we    <= 1'b0;
            req_wdata <= '0;
            rx_ready  <= 1'b0;
            tx_valid  <= 1'b0;
            tx_data   <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        req_addr <= address_sync;
                        req_we   <= ~rd_wr_sync;
                        abort    <= 1'b0;
                        busy     <= 1'b1;
                        if (rd_wr_sync) begin
                            req_valid <= 1'b1;
                            state     <= ST_REQ;
                        end else begin
                            rx_ready <= 1'b1;
                            state    <= ST_WDATA;
                        end
                    end
                end
                ST_WDATA: begin
                    if (cs_sync) begin
                        rx_ready <= 1'b0;
                        busy     <= 1'b0;
                        state    <= ST_IDLE;
                    end else if (rx_valid) begin
                        req_wdata <= rx_data;
                        rx_ready  <= 1'b0;
                        req_valid <= 1'b1;
                        state     <= ST_REQ;
                    end
                end
                ST_REQ: begin
                    if (cs_sync) abort <= 1'b1;
                    if (req_ready) begin
                        req_valid <= 1'b0;
                        state     <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    if (cs_sync) abort <= 1'b1;
                    if (rsp_valid) begin
                        req_addr <= req_addr + ADDR_INC;
                        // A deselect seen during the bus cycle ends the transfer once the response lands.
                        if (abort || cs_sync) begin
                            busy  <= 1'b0;
                            state <= ST_IDLE;
                        end else if (req_we) begin
                            rx_ready <= 1'b1;
                            state    <= ST_WDATA;
                        end else begin
                            tx_data  <= rsp_rdata;
                            tx_valid <= 1'b1;
                            state    <= ST_PUSH;
                        end
                    end
                end
                ST_PUSH: begin
                    if (cs_sync) begin
                        tx_valid <= 1'b0;
                        busy     <= 1'b0;
                        state    <= ST_IDLE;
                    end else if (tx_ready) begin
                        tx_valid  <= 1'b0;
                        req_valid <= 1'b1;
                        state     <= ST_REQ;
                    end
                end
                default: begin
                    busy      <= 1'b0;
                    req_valid <= 1'b0;
                    rx_ready  <= 1'b0;
                    tx_valid  <= 1'b0;
                    state     <= ST_IDLE;
                end
            endcase
        end
    end

`ifdef SPI_SLAVE_REQ_ERR_EN
    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            err_flag <= 1'b0;
            err_cnt  <= '0;
        end else if (state == ST_IDLE && start) begin
            err_flag <= 1'b0;
            err_cnt  <= '0;
        end else if (state == ST_RESP && rsp_valid && rsp_err) begin
            err_flag <= 1'b1;
            if (err_cnt != ERR_CNT_MAX) err_cnt <= err_cnt + 8'd1;
        end
    end
`else
    logic unused_rsp_err;
    assign unused_rsp_err = rsp_err;
    assign err_flag       = 1'b0;
    assign err_cnt        = '0;
`endif

endmodule

// File: tb/tb_spi_slave_bus_req.sv
// Self-checking bench: table of transfers, bus/stream models feeding scoreboards,
// plus hand-written deselect, error-count and reset-in-RESP sequences.
module tb_spi_slave_bus_req;
    import spi_slave_pkg::*;

`ifdef SPI_SLAVE_REQ_ERR_EN
    localparam int         N_ERR     = 300;
    localparam logic       EXP_EFLAG = 1'b1;
    localparam logic [7:0] EXP_ECNT  = 8'd255;
`else
    localparam int         N_ERR     = 6;
    localparam logic       EXP_EFLAG = 1'b0;
    localparam logic [7:0] EXP_ECNT  = 8'd0;
`endif

    logic        sys_clk = 1'b0;
    logic        rst;
    logic        cs_sync;
    logic [31:0] address_sync;
    logic        address_valid_sync;
    logic        rd_wr_sync;
    logic [31:0] rx_data;
    logic        rx_valid;
    logic        rx_ready;
    logic [31:0] tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_addr;
    logic        req_we;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        busy;
    logic        err_flag;
    logic [7:0]  err_cnt;

    spi_slave_bus_req #(.WORD_BYTES(4)) dut (
        .sys_clk            (sys_clk),
        .rst                (rst),
        .cs_sync            (cs_sync),
        .address_sync       (address_sync),
        .address_valid_sync (address_valid_sync),
        .rd_wr_sync         (rd_wr_sync),
        .rx_data            (rx_data),
        .rx_valid           (rx_valid),
        .rx_ready           (rx_ready),
        .tx_data            (tx_data),
        .tx_valid           (tx_valid),
        .tx_ready           (tx_ready),
        .req_valid          (req_valid),
        .req_ready          (req_ready),
        .req_addr           (req_addr),
        .req_we             (req_we),
        .req_wdata          (req_wdata),
        .rsp_valid          (rsp_valid),
        .rsp_rdata          (rsp_rdata),
        .rsp_err            (rsp_err),
        .busy               (busy),
        .err_flag           (err_flag),
        .err_cnt            (err_cnt)
    );

    always #5 sys_clk = ~sys_clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [31:0] addr;
        logic        we;
        logic [31:0] wdata;
    } req_t;

    typedef struct {
        bit          rd;
        logic [31:0] addr;
        int          n;
        logic [31:0] data;
    } vec_t;

    req_t        exp_req_q[$];
    logic [31:0] exp_tx_q[$];
    logic [31:0] rx_q[$];

    int          hold_cycles = 0;
    int          wait_cnt    = 0;
    bit          resp_due    = 1'b0;
    bit          rsp_hold    = 1'b0;
    bit          err_mode    = 1'b0;
    logic [31:0] rd_base     = 32'h0;
    int          rd_idx      = 0;
    int          tx_cnt      = 0;
    bit          tx_seen     = 1'b0;

    // Bus slave: grants after hold_cycles, answers one cycle after the grant.
    initial begin
        req_ready = 1'b0;
        rsp_valid = 1'b0;
        rsp_rdata = 32'h0;
        rsp_err   = 1'b0;
        forever begin
            @(negedge sys_clk);
            rsp_valid = 1'b0;
            rsp_err   = 1'b0;
            if (resp_due && !rsp_hold) begin
                rsp_valid = 1'b1;
                rsp_rdata = rd_base + 32'(rd_idx);
                rsp_err   = err_mode;
                rd_idx++;
                resp_due  = 1'b0;
            end
            req_ready = 1'b0;
            if (req_valid) begin
                if (wait_cnt < hold_cycles) begin
                    wait_cnt++;
                end else begin
                    req_t e;
                    req_ready = 1'b1;
                    wait_cnt  = 0;
                    resp_due  = 1'b1;
                    if (exp_req_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_req: got addr %h we %b expected no request", req_addr, req_we);
                    end else begin
                        e = exp_req_q.pop_front();
                        check("req_addr", 64'(req_addr), 64'(e.addr));
                        check("req_we", 64'(req_we), 64'(e.we));
                        if (e.we) check("req_wdata", 64'(req_wdata), 64'(e.wdata));
                    end
                end
            end
        end
    end

    // Read-data sink.
    initial begin
        tx_ready = 1'b0;
        forever begin
            @(negedge sys_clk);
            tx_ready = 1'b0;
            if (tx_valid) begin
                tx_seen = 1'b1;
                if (exp_tx_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_tx: got %h expected no tx word", tx_data);
                end else begin
                    check("tx_data", 64'(tx_data), 64'(exp_tx_q.pop_front()));
                    tx_ready = 1'b1;
                    tx_cnt++;
                end
            end
        end
    end

    // Write-data source.
    initial begin
        rx_valid = 1'b0;
        rx_data  = 32'h0;
        forever begin
            @(negedge sys_clk);
            rx_valid = 1'b0;
            if (rx_ready && rx_q.size() > 0) begin
                rx_data  = rx_q.pop_front();
                rx_valid = 1'b1;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish expected finish before time limit");
        $fatal(1, "watchdog");
    end

    task automatic start_xfer(input logic rd, input logic [31:0] addr);
        @(negedge sys_clk);
        #1;
        check("busy_before_start", 64'(busy), 64'd0);
        cs_sync            = 1'b0;
        address_sync       = addr;
        rd_wr_sync         = rd;
        address_valid_sync = 1'b1;
        @(posedge sys_clk);
        #1;
        if (rd) check("req_valid_next_cycle", 64'(req_valid), 64'd1);
        else    check("rx_ready_next_cycle", 64'(rx_ready), 64'd1);
    endtask

    task automatic wait_idle(input string name);
        bit done = 1'b0;
        for (int i = 0; i < 2000 && !done; i++) begin
            @(negedge sys_clk);
            #1;
            if (!busy) done = 1'b1;
        end
        check(name, 64'(done), 64'd1);
    endtask

    task automatic end_xfer(input string name);
        @(negedge sys_clk);
        #1;
        cs_sync            = 1'b1;
        address_valid_sync = 1'b0;
        wait_idle(name);
        check("req_valid_idle", 64'(req_valid), 64'd0);
        check("tx_valid_idle", 64'(tx_valid), 64'd0);
        check("rx_ready_idle", 64'(rx_ready), 64'd0);
    endtask

    // Read of n words: n pushes plus one prefetch absorbed by the deselect.
    task automatic do_read(input logic [31:0] addr, input int n, input logic [31:0] base, input bit err);
        bit done = 1'b0;
        rd_base  = base;
        rd_idx   = 0;
        err_mode = err;
        tx_cnt   = 0;
        for (int i = 0; i <= n; i++) exp_req_q.push_back('{addr: addr + 32'(i * 4), we: 1'b0, wdata: 32'h0});
        for (int i = 0; i < n; i++) exp_tx_q.push_back(base + 32'(i));
        start_xfer(1'b1, addr);
        for (int i = 0; i < 5000 && !done; i++) begin
            @(negedge sys_clk);
            #1;
            if (tx_cnt == n) done = 1'b1;
        end
        check("read_words_done", 64'(done), 64'd1);
        end_xfer("read_to_idle");
        check("read_req_q_empty", 64'(exp_req_q.size()), 64'd0);
        check("read_tx_q_empty", 64'(exp_tx_q.size()), 64'd0);
        err_mode = 1'b0;
        exp_req_q.delete();
        exp_tx_q.delete();
    endtask

    task automatic do_write(input logic [31:0] addr, input int n, input logic [31:0] step);
        bit done = 1'b0;
        for (int i = 0; i < n; i++) begin
            exp_req_q.push_back('{addr: addr + 32'(i * 4), we: 1'b1, wdata: step * 32'(i + 1)});
            rx_q.push_back(step * 32'(i + 1));
        end
        start_xfer(1'b0, addr);
        for (int i = 0; i < 2000 && !done; i++) begin
            @(negedge sys_clk);
            #1;
            if (exp_req_q.size() == 0 && rx_ready) done = 1'b1;
        end
        check("write_words_done", 64'(done), 64'd1);
        end_xfer("write_to_idle");
        check("write_rx_q_empty", 64'(rx_q.size()), 64'd0);
        exp_req_q.delete();
        rx_q.delete();
    endtask

    vec_t vecs[5];

    initial begin
        vecs[0] = '{rd: 1'b1, addr: 32'h0000_1000, n: 2, data: 32'hA5A5_0001};
        vecs[1] = '{rd: 1'b0, addr: 32'h0000_2000, n: 2, data: 32'h0000_0011};
        vecs[2] = '{rd: 1'b1, addr: 32'hFFFF_FFFC, n: 2, data: 32'h0BAD_0000};
        vecs[3] = '{rd: 1'b0, addr: 32'hFFFF_FFF8, n: 3, data: 32'h0000_0100};
        vecs[4] = '{rd: 1'b1, addr: 32'h0000_0000, n: 3, data: 32'h1234_5670};

        rst                = 1'b1;
        cs_sync            = 1'b1;
        address_sync       = 32'h0;
        address_valid_sync = 1'b0;
        rd_wr_sync         = 1'b0;
        repeat (3) @(negedge sys_clk);
        #1;
        check("reset_ctrl", 64'({busy, req_valid, req_we, rx_ready, tx_valid, err_flag, err_cnt}), 64'd0);
        check("reset_req_addr", 64'(req_addr), 64'd0);
        check("reset_data", {req_wdata, tx_data}, 64'd0);
        rst = 1'b0;

        for (int v = 0; v < 5; v++) begin
            if (vecs[v].rd) do_read(vecs[v].addr, vecs[v].n, vecs[v].data, 1'b0);
            else            do_write(vecs[v].addr, vecs[v].n, vecs[v].data);
            check("err_clean", 64'({err_flag, err_cnt}), 64'd0);
        end

        // Deselect while the grant is withheld: request holds, response is absorbed.
        hold_cycles = 3;
        tx_seen     = 1'b0;
        rd_base     = 32'hDEAD_0000;
        rd_idx      = 0;
        exp_req_q.push_back('{addr: 32'h0000_3000, we: 1'b0, wdata: 32'h0});
        start_xfer(1'b1, 32'h0000_3000);
        cs_sync            = 1'b1;
        address_valid_sync = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge sys_clk);
            #1;
            check("req_valid_held", 64'(req_valid), 64'd1);
            check("req_addr_held", 64'(req_addr), 64'h3000);
        end
        wait_idle("cs_abort_to_idle");
        check("cs_abort_req_q_empty", 64'(exp_req_q.size()), 64'd0);
        check("cs_abort_rsp_consumed", 64'(resp_due), 64'd0);
        check("cs_abort_no_tx", 64'(tx_seen), 64'd0);
        hold_cycles = 0;

        // Error responses saturate the counter; the next start clears it.
        do_read(32'h0000_4000, N_ERR, 32'h0000_E000, 1'b1);
        check("err_flag_set", 64'(err_flag), 64'(EXP_EFLAG));
        check("err_cnt_sat", 64'(err_cnt), 64'(EXP_ECNT));
        do_read(32'h0000_5000, 1, 32'h0000_5500, 1'b0);
        check("err_cleared", 64'({err_flag, err_cnt}), 64'd0);

        // Reset while waiting for the response.
        rsp_hold = 1'b1;
        tx_seen  = 1'b0;
        exp_req_q.push_back('{addr: 32'h0000_6000, we: 1'b0, wdata: 32'h0});
        start_xfer(1'b1, 32'h0000_6000);
        begin
            bit granted = 1'b0;
            for (int i = 0; i < 100 && !granted; i++) begin
                @(negedge sys_clk);
                #1;
                if (exp_req_q.size() == 0) granted = 1'b1;
            end
            check("rst_test_granted", 64'(granted), 64'd1);
        end
        @(negedge sys_clk);
        #1;
        check("in_resp_busy", 64'({busy, req_valid}), 64'b10);
        rst = 1'b1;
        #1;
        check("rst_mid_ctrl", 64'({busy, req_valid, req_we, rx_ready, tx_valid, err_flag, err_cnt}), 64'd0);
        check("rst_mid_req_addr", 64'(req_addr), 64'd0);
        check("rst_mid_data", {req_wdata, tx_data}, 64'd0);
        cs_sync            = 1'b1;
        address_valid_sync = 1'b0;
        @(negedge sys_clk);
        #1;
        rst      = 1'b0;
        rsp_hold = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge sys_clk);
            #1;
            check("late_rsp_ignored", 64'({busy, req_valid, tx_valid, rx_ready}), 64'd0);
        end
        check("late_rsp_delivered", 64'(resp_due), 64'd0);
        check("late_rsp_no_tx", 64'(tx_seen), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
